alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_addsub.sv | 33 +++
 rtl/alu.sv | 125 ++++++++++++
 tb/tb_alu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_pkg                                            |
// | Description : Shared constants for the ALU: default datapath     |
// |               width, operation codes and flag bit positions.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   // Operation select encodings
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   // Bit positions inside the {N,Z,C,V} flags vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_addsub                                         |
// | Description : Combinational adder/subtractor. carry_o is the     |
// |               carry-out for ADD and the borrow (x < y unsigned)  |
// |               for SUB; ovf_o is signed overflow for both.        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module alu_addsub #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] y_eff;
   logic [WIDTH:0]   ext;

   // Subtraction is x + ~y + 1; the raw carry-out is the inverted borrow.
   always_comb begin
      y_eff   = sub ? ~y : y;
      ext     = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
      sum     = ext[WIDTH-1:0];
      carry_o = ext[WIDTH] ^ sub;
      ovf_o   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
   end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu                                                |
// | Description : Single-cycle registered ALU with register/immediate|
// |               operand select. Optional {N,Z,C,V} flags output    |
// |               enabled by defining macro ALU_FLAGS_EN.            |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       codeop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] rd,
   input  logic             ri,
`ifdef ALU_FLAGS_EN
   output logic [3:0]       flags,
`endif
   output logic [WIDTH-1:0] r,
   output logic             cmp
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [SH_W-1:0]  sh_amt;
   logic [WIDTH:0]   shl_ext;   // bit WIDTH holds the last bit shifted out
   logic [WIDTH:0]   shr_ext;   // bit 0 holds the last bit shifted out
   logic [WIDTH-1:0] as_sum;
   logic             as_carry;
   logic             as_ovf;

   logic [WIDTH-1:0] r_d,   r_q;
   logic             cmp_d, cmp_q;

   // Operand routing and shifters; only the low SH_W bits of Y set the amount.
   always_comb begin
      x       = a;
      y       = ri ? rd : b;
      sh_amt  = y[SH_W-1:0];
      shl_ext = {1'b0, x} << sh_amt;
      shr_ext = {x, 1'b0} >> sh_amt;
   end

   alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .x       (x),
      .y       (y),
      .sub     (codeop == OP_SUB),
      .sum     (as_sum),
      .carry_o (as_carry),
      .ovf_o   (as_ovf)
   );

   // Result and compare selection for the operation sampled this cycle.
   always_comb begin
      r_d   = '0;
      cmp_d = 1'b0;
      case (codeop)
         OP_ADD, OP_SUB: r_d   = as_sum;
         OP_AND:         r_d   = x & y;
         OP_OR:          r_d   = x | y;
         OP_XOR:         r_d   = x ^ y;
         OP_SHL:         r_d   = shl_ext[WIDTH-1:0];
         OP_SHR:         r_d   = shr_ext[WIDTH:1];
         OP_CMP:         cmp_d = (x == y);
         default:        r_d   = '0;
      endcase
   end

   // Output registers; reset wins over any operation in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '0;
         cmp_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         cmp_q <= cmp_d;
      end
   end

   assign r   = r_q;
   assign cmp = cmp_q;

`ifdef ALU_FLAGS_EN
   logic [3:0] flags_d, flags_q;

   // Flags derive from the same next-state result that r captures.
   always_comb begin
      flags_d         = 4'b0000;
      flags_d[FLAG_N] = r_d[WIDTH-1];
      flags_d[FLAG_Z] = (r_d == '0);
      case (codeop)
         OP_ADD, OP_SUB: begin
            flags_d[FLAG_C] = as_carry;
            flags_d[FLAG_V] = as_ovf;
         end
         OP_SHL:  flags_d[FLAG_C] = shl_ext[WIDTH];
         OP_SHR:  flags_d[FLAG_C] = shr_ext[0];
         default: flags_d[FLAG_C] = 1'b0;
      endcase
   end

   // Flags register, cleared with the rest of the outputs.
   always_ff @(posedge clk) begin
      if (rst) flags_q <= 4'b0000;
      else     flags_q <= flags_d;
   end

   assign flags = flags_q;
`else
   // Carry/overflow and the shifted-out bits only feed the flags.
   logic unused_flag_srcs;
   assign unused_flag_srcs = &{1'b0, as_carry, as_ovf, shl_ext[WIDTH], shr_ext[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_alu                                             |
// | Description : Self-checking bench for alu: directed vector table,|
// |               reset sequences and random stimulus against a      |
// |               behavioural model. Flags checked when ALU_FLAGS_EN.|
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  codeop;
   logic [15:0] a, b, rd;
   logic        ri;
   logic [15:0] r;
   logic        cmp;
`ifdef ALU_FLAGS_EN
   logic [3:0]  flags;
`endif

   int checks   = 0;
   int failures = 0;

   alu #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .codeop (codeop),
      .a      (a),
      .b      (b),
      .rd     (rd),
      .ri     (ri),
`ifdef ALU_FLAGS_EN
      .flags  (flags),
`endif
      .r      (r),
      .cmp    (cmp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] va, vb, vrd;
      logic        vri;
      logic [15:0] er;
      logic        ec;
      logic [3:0]  ef;
      logic        fv;   // ef is a hand-derived expectation to check
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Behavioural model: plain integer arithmetic on the documented rules.
   function automatic void model(input logic [2:0] op, input logic [15:0] ia, ib, ird,
                                 input logic iri, output logic [15:0] mr,
                                 output logic mc, output logic [3:0] mf);
      int x, y, n, res, sx, sy, sres, c, v;
      x = int'(ia);
      y = iri ? int'(ird) : int'(ib);
      n = y % 16;
      c = 0; v = 0; mc = 1'b0;
      sx = (x >= 32768) ? x - 65536 : x;
      sy = (y >= 32768) ? y - 65536 : y;
      case (op)
         3'd0: begin res = x + y; c = (res >= 65536) ? 1 : 0;
                     sres = sx + sy; v = (sres > 32767 || sres < -32768) ? 1 : 0; end
         3'd1: begin res = x - y; c = (x < y) ? 1 : 0;
                     sres = sx - sy; v = (sres > 32767 || sres < -32768) ? 1 : 0; end
         3'd2: res = x & y;
         3'd3: res = x | y;
         3'd4: res = x ^ y;
         3'd5: begin res = x << n; c = (n == 0) ? 0 : (x >> (16 - n)) & 1; end
         3'd6: begin res = x >> n; c = (n == 0) ? 0 : (x >> (n - 1)) & 1; end
         default: begin res = 0; mc = (x == y); end
      endcase
      res = res & 32'hFFFF;
      mr = res[15:0];
      mf = {mr[15], (res == 0), c[0], v[0]};
   endfunction

   task automatic drive(input logic [2:0] op, input logic [15:0] ia, ib, ird, input logic iri);
      @(negedge clk);
      codeop = op; a = ia; b = ib; rd = ird; ri = iri;
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string nm, input logic [2:0] op,
                              input logic [15:0] ia, ib, ird, input logic iri);
      logic [15:0] mr; logic mc; logic [3:0] mf;
      model(op, ia, ib, ird, iri, mr, mc, mf);
      chk({nm, "_r"}, {16'h0, r}, {16'h0, mr});
      chk({nm, "_cmp"}, {31'h0, cmp}, {31'h0, mc});
`ifdef ALU_FLAGS_EN
      chk({nm, "_flags"}, {28'h0, flags}, {28'h0, mf});
`endif
   endtask

   initial begin
      // Directed vectors: operation sweeps, compare, wrap, shift amount masking, borrow.
      for (int i = 0; i < 8; i++) begin
         logic [15:0] e0 [8];
         logic [15:0] e1 [8];
         e0 = '{16'h000D, 16'h0001, 16'h0006, 16'h0007, 16'h0001, 16'h01C0, 16'h0000, 16'h0000};
         e1 = '{16'h000C, 16'h0002, 16'h0005, 16'h0007, 16'h0002, 16'h00E0, 16'h0000, 16'h0000};
         tbl.push_back('{3'(i), 16'd7, 16'd6, 16'd5, 1'b0, e0[i], 1'b0, 4'h0, 1'b0});
         tbl.push_back('{3'(i), 16'd7, 16'd6, 16'd5, 1'b1, e1[i], 1'b0, 4'h0, 1'b0});
      end
      tbl.push_back('{3'd7, 16'd5, 16'd9, 16'd5, 1'b1, 16'h0000, 1'b1, 4'b0100, 1'b1});
      tbl.push_back('{3'd7, 16'd5, 16'd6, 16'd5, 1'b0, 16'h0000, 1'b0, 4'b0100, 1'b1});
      tbl.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0110, 1'b1});
      tbl.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h8000, 1'b0, 4'b1001, 1'b1});
      tbl.push_back('{3'd5, 16'h0001, 16'h0013, 16'h0000, 1'b0, 16'h0008, 1'b0, 4'b0000, 1'b1});
      tbl.push_back('{3'd1, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 4'b1010, 1'b1});
      tbl.push_back('{3'd6, 16'h8001, 16'h00F1, 16'h0000, 1'b0, 16'h4000, 1'b0, 4'b0010, 1'b1});

      // Reset state with busy inputs present
      rst = 1'b1; codeop = 3'd0; a = 16'h1234; b = 16'h4321; rd = 16'h0; ri = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_r", {16'h0, r}, 32'h0);
      chk("reset_cmp", {31'h0, cmp}, 32'h0);
`ifdef ALU_FLAGS_EN
      chk("reset_flags", {28'h0, flags}, 32'h0);
`endif
      @(negedge clk); rst = 1'b0;

      // Table, one vector per cycle back to back
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].va, tbl[i].vb, tbl[i].vrd, tbl[i].vri);
         chk($sformatf("vec%0d_r", i), {16'h0, r}, {16'h0, tbl[i].er});
         chk($sformatf("vec%0d_cmp", i), {31'h0, cmp}, {31'h0, tbl[i].ec});
`ifdef ALU_FLAGS_EN
         if (tbl[i].fv)
            chk($sformatf("vec%0d_flags", i), {28'h0, flags}, {28'h0, tbl[i].ef});
`endif
      end

      // Reset mid-stream with an ADD pending, then release
      drive(3'd4, 16'h00F0, 16'h0FF0, 16'h0, 1'b0);
      check_model("pre_rst", 3'd4, 16'h00F0, 16'h0FF0, 16'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1; codeop = 3'd0; a = 16'h1111; b = 16'h2222;
      @(posedge clk); #1;
      chk("midrst_r", {16'h0, r}, 32'h0);
      chk("midrst_cmp", {31'h0, cmp}, 32'h0);
`ifdef ALU_FLAGS_EN
      chk("midrst_flags", {28'h0, flags}, 32'h0);
`endif
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("postrst_r", {16'h0, r}, 32'h3333);

      // Compare that is true on one cycle and false on the next
      drive(3'd7, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b1);
      check_model("cmp_true", 3'd7, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b1);
      drive(3'd7, 16'hBEEF, 16'hBEEE, 16'hBEEF, 1'b0);
      check_model("cmp_false", 3'd7, 16'hBEEF, 16'hBEEE, 16'hBEEF, 1'b0);

      // Random stimulus against the model, a new operation every cycle
      for (int k = 0; k < 400; k++) begin
         logic [2:0]  op; logic [15:0] ra, rb, rrd; logic rri;
         op  = 3'($urandom_range(0, 7));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rrd = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
         rri = 1'($urandom);
         drive(op, ra, rb, rrd, rri);
         check_model($sformatf("rand%0d", k), op, ra, rb, rrd, rri);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
